// File: rtl/hazard_stall_controller_if.sv
// Control/status bundle between the MIPS datapath stage registers and the hazard/stall controller.
// Signal directions are named from the controller's point of view.
interface hazard_stall_controller_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      i_ifid_im;
    logic             i_idex_mem_read;
    logic [4:0]       i_idex_write_reg;
    logic             i_md_start;
    logic             i_branch_taken;
    logic             i_jump;
    logic             o_pc_write;
    logic             o_ifid_write;
    logic             o_ifid_flush;
    logic             o_idex_write;
    logic             o_idex_flush;
    logic             o_exmem_flush;
    logic [CNT_W-1:0] o_stall_cycles;
    logic [CNT_W-1:0] o_flush_events;

    modport slave (
        input  i_ifid_im, i_idex_mem_read, i_idex_write_reg, i_md_start, i_branch_taken, i_jump,
        output o_pc_write, o_ifid_write, o_ifid_flush, o_idex_write, o_idex_flush, o_exmem_flush,
        output o_stall_cycles, o_flush_events
    );

    modport master (
        output i_ifid_im, i_idex_mem_read, i_idex_write_reg, i_md_start, i_branch_taken, i_jump,
        input  o_pc_write, o_ifid_write, o_ifid_flush, o_idex_write, o_idex_flush, o_exmem_flush,
        input  o_stall_cycles, o_flush_events
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Load-use, multicycle mult/div, branch and jump hazard control for the 5-stage pipeline,
// with saturating stall/flush performance counters.
//
// state         | meaning
// ST_RUN        | normal issue; LU/jump/branch handled combinationally
// ST_MD_BUSY    | mult/div in EX, front end frozen while mdcnt runs down
// ST_MD_RELEASE | one cycle after the freeze; the same mult/div is still in EX
module hazard_stall_controller #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 16
) (
    input logic                          Clk,
    input logic                          Rst,
    hazard_stall_controller_if.slave     io_hz
);
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MD_BUSY    = 2'd1,
        ST_MD_RELEASE = 2'd2
    } state_t;

    localparam logic [15:0] MD_INIT = 16'(MD_LATENCY - 2);

    state_t           r_state, w_state_nxt;
    logic [15:0]      r_mdcnt, w_mdcnt_nxt;
    logic [CNT_W-1:0] r_stall_cycles, r_flush_events;

    logic [5:0] w_opcode;
    logic [4:0] w_rs, w_rt;
    logic       w_uses_rt, w_lu;
    logic       w_pc_write, w_ifid_write, w_ifid_flush;
    logic       w_idex_write, w_idex_flush, w_exmem_flush;

    assign w_opcode = io_hz.i_ifid_im[31:26];
    assign w_rs     = io_hz.i_ifid_im[25:21];
    assign w_rt     = io_hz.i_ifid_im[20:16];

    // R-type, beq, bne and the stores read rt as a source operand
    always_comb begin
        case (w_opcode)
            6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B: w_uses_rt = 1'b1;
            default:                                w_uses_rt = 1'b0;
        endcase
    end

    assign w_lu = io_hz.i_idex_mem_read && (io_hz.i_idex_write_reg != 5'd0) &&
                  ((io_hz.i_idex_write_reg == w_rs) ||
                   ((io_hz.i_idex_write_reg == w_rt) && w_uses_rt));

    always_comb begin
        w_state_nxt   = r_state;
        w_mdcnt_nxt   = r_mdcnt;
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_write  = 1'b1;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;
        if (Rst) begin
            w_state_nxt = ST_RUN;
            w_mdcnt_nxt = 16'd0;
        end else if (io_hz.i_branch_taken) begin
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_exmem_flush = 1'b1;
            w_state_nxt   = ST_RUN;
            w_mdcnt_nxt   = 16'd0;
        end else if (((r_state == ST_RUN) && io_hz.i_md_start) || (r_state == ST_MD_BUSY)) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_write  = 1'b0;
            w_exmem_flush = 1'b1;
            if (r_state == ST_RUN) begin
                w_state_nxt = ST_MD_BUSY;
                w_mdcnt_nxt = MD_INIT;
            end else if (r_mdcnt == 16'd0) begin
                w_state_nxt = ST_MD_RELEASE;
            end else begin
                w_mdcnt_nxt = r_mdcnt - 16'd1;
            end
        end else begin
            w_state_nxt = ST_RUN;
            if (w_lu) begin
                // jump stays in IF/ID and is flushed once the load has moved on
                w_pc_write   = 1'b0;
                w_ifid_write = 1'b0;
                w_idex_flush = 1'b1;
            end else if (io_hz.i_jump) begin
                w_ifid_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state        <= ST_RUN;
            r_mdcnt        <= 16'd0;
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mdcnt <= w_mdcnt_nxt;
            if (!w_pc_write && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 1'b1;
            if (w_ifid_flush && (r_flush_events != '1))
                r_flush_events <= r_flush_events + 1'b1;
        end
    end

    assign io_hz.o_pc_write     = w_pc_write;
    assign io_hz.o_ifid_write   = w_ifid_write;
    assign io_hz.o_ifid_flush   = w_ifid_flush;
    assign io_hz.o_idex_write   = w_idex_write;
    assign io_hz.o_idex_flush   = w_idex_flush;
    assign io_hz.o_exmem_flush  = w_exmem_flush;
    assign io_hz.o_stall_cycles = r_stall_cycles;
    assign io_hz.o_flush_events = r_flush_events;
endmodule
